rr_tag_arbiter: RTL and testbench
=================================

Name: rr_tag_arbiter

Overview:
- N-way arbiter that replaces the combinational tag tree in the snoop and forward arbitration paths.
- Presents one requester at a time on a tag/rdy/ack handshake.
- Adds a registered grant, round-robin fairness (or fixed priority), withdrawal handling and a per-grant latency guarantee.
- Sits between the parallel cores' rdy/ack lines and the packet-memory snooper and forwarder.

Parameters:
- N, 4, number of requesters; 1 to 1024 inclusive.
- TAG_SZ, CLOG2(N) (1 when N<=2), width of tag and of the internal pointer.
- CUSTOM_TAGS, 0, when 1, tag = custom_tags slice k for grant k; when 0, tag = k.
- RR_MODE, 1, 1 = round-robin from pointer; 0 = fixed priority, lowest index wins.
- BACK_TO_BACK, 0, when 1, the ack cycle also selects the next grant (no IDLE bubble).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- tag  output  TAG_SZ  tag of current grant; valid only while rdy=1.
- rdy  output  1  a grant is being offered.
- ack  input  1  consumer accepts current grant; sampled only when rdy=1.
- rdy_in  input  N  per-requester ready.
- ack_out  output  N  one-hot, combinational pulse to the granted requester.
- custom_tags  input  N*TAG_SZ  slice k = custom_tags[TAG_SZ*(k+1)-1 -: TAG_SZ]; ignored when CUSTOM_TAGS=0.

Behaviour:
- State: fsm {IDLE, OFFER}, grant index g (TAG_SZ), round-robin pointer p (TAG_SZ).
- Reset (rst=0, async): fsm=IDLE, g=0, p=0. Outputs: rdy=0, tag=0, ack_out=0. Reset mid-OFFER drops rdy immediately with no ack_out pulse.
- Selection function sel(mask, start):
  - RR_MODE=1: first set bit of mask scanning start, start+1, …, N-1, 0, …, start-1.
  - RR_MODE=0: lowest set index; start ignored.
  - Combinational priority logic, then registered into g.
- IDLE:
  - If |rdy_in, then g<=sel(rdy_in,p) and fsm<=OFFER.
  - Otherwise stay in IDLE.
  - Latency from rdy_in rising to rdy rising is exactly 1 cycle.
- OFFER:
  - Outputs: rdy=rdy_in[g]; tag = g or custom slice g.
  - ack_out[g] = ack & rdy_in[g], same cycle; all other bits 0.
- OFFER with ack=1 and rdy_in[g]=1 (accept):
  - p <= (g==N-1) ? 0 : g+1, wrapping at N, not at 2^TAG_SZ.
  - BACK_TO_BACK=0: fsm<=IDLE.
  - BACK_TO_BACK=1: mask = rdy_in with bit g cleared. If |mask, then g<=sel(mask,g+1 wrapped) and stay in OFFER; else fsm<=IDLE.
- OFFER with rdy_in[g]=0 (withdrawal): fsm<=IDLE, p unchanged, no ack_out. An ack in this cycle is ignored.
- ack while rdy=0 has no effect.
- Other rdy_in changes during OFFER do not alter g; the grant is held until accept or withdrawal.
- N=1: p is constant 0, g is always 0.
- Fairness (RR_MODE=1, BACK_TO_BACK=1, consumer acks every offer): a continuously ready requester is granted within N-1 grants of any other requester.
- No combinational path from ack to rdy or tag. ack_out does depend combinationally on ack.

Test Plan:
- Reset: hold rst=0 with rdy_in=4'b1111. Expect rdy=0 and ack_out=0. Release rst: rdy=1 one cycle later with tag=0.
- Round-robin, N=4, RR_MODE=1: rdy_in=4'b1111 held, ack every offer, BACK_TO_BACK=0. Tags 0,1,2,3,0 appear, with one IDLE cycle between offers.
- Back-to-back plus wrap, N=4, BACK_TO_BACK=1: rdy_in=4'b1001, ack each cycle. Tags alternate 0,3,0,3 with rdy continuously 1; ack_out alternates 4'b0001/4'b1000.
- Withdrawal: grant at tag 2, then rdy_in[2]->0 with ack=1 in the same cycle. Expect rdy=0 in that cycle, ack_out=0, and p stays at 2; the next grant with rdy_in=4'b1111 is tag 2.
- Fixed priority, RR_MODE=0: rdy_in=4'b1110 held with ack every offer. Tag is always 1; requesters 2 and 3 are never granted.
- Custom tags and N=1: with N=3 and CUSTOM_TAGS=1, custom_tags={2'd1,2'd3,2'd2}; granting requester 0 shows tag=2. With N=1: rdy_in=1 gives tag=0, rdy=1 after 1 cycle, and ack gives ack_out=1.

Source files
------------

// File: rtl/rr_tag_arbiter.sv
// rr_tag_arbiter
// N-way request arbiter for the snoop and forward paths. It offers one
// requester at a time to a consumer over a tag/rdy/ack handshake. The grant is
// registered, and arbitration is either round-robin from a rotating pointer or
// fixed priority. It handles requester withdrawal and, optionally, back-to-back
// grants.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous reset, active low
//   tag          tag of the current grant (index or custom tag), 0 while idle
//   rdy          a grant is being offered
//   ack          consumer accepts the current grant (only meaningful with rdy)
//   rdy_in       per-requester ready
//   ack_out      one-hot accept pulse to the granted requester (combinational)
//   custom_tags  packed per-requester tags, slice k = [TAG_SZ*k +: TAG_SZ]
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant held; any ready requester is selected on the next edge
// ST_OFFER | grant g_q held and offered while its requester stays ready

module rr_tag_arbiter #(
    parameter int N            = 4,
    parameter int TAG_SZ       = (N <= 2) ? 1 : $clog2(N),
    parameter bit CUSTOM_TAGS  = 1'b0,
    parameter bit RR_MODE      = 1'b1,
    parameter bit BACK_TO_BACK = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    output logic [TAG_SZ-1:0]   tag,
    output logic                rdy,
    input  logic                ack,
    input  logic [N-1:0]        rdy_in,
    output logic [N-1:0]        ack_out,
    input  logic [N*TAG_SZ-1:0] custom_tags
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [TAG_SZ-1:0]   g_q, g_d;
    logic [TAG_SZ-1:0]   p_q, p_d;

    logic [N-1:0]        onehot_g;
    logic                cur_rdy;
    logic [TAG_SZ-1:0]   ctag;
    logic [N-1:0]        rest_mask;
    logic                offering;
    logic                accept;
    int                  next_ptr;

    // Rotate the request mask so that 'start' lands on bit 0, take the lowest
    // set bit, then map it back to a requester index modulo N. In fixed
    // priority mode the rotation is zero, so the lowest index always wins.
    function automatic logic [TAG_SZ-1:0] sel(input logic [N-1:0] mask,
                                              input int           start);
        logic [2*N-1:0] rot;
        int             base;
        int             hit;
        int             idx;
        base = (RR_MODE != 1'b0) ? start : 0;
        rot  = {mask, mask} >> base;
        hit  = 0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) begin
                hit = j;
            end
        end
        idx = base + hit;
        if (idx >= N) begin
            idx = idx - N;
        end
        return TAG_SZ'(idx);
    endfunction

    // Decode the held grant index. Comparing against each k keeps this valid
    // when N is not a power of two and the index width exceeds the range.
    always_comb begin
        onehot_g = '0;
        cur_rdy  = 1'b0;
        ctag     = '0;
        for (int k = 0; k < N; k++) begin
            if (int'(g_q) == k) begin
                onehot_g[k] = 1'b1;
                cur_rdy     = rdy_in[k];
                ctag        = custom_tags[TAG_SZ*k +: TAG_SZ];
            end
        end
    end

    // The pointer wraps at N, not at 2^TAG_SZ.
    always_comb begin
        next_ptr = (int'(g_q) == N - 1) ? 0 : int'(g_q) + 1;
    end

    assign rest_mask = rdy_in & ~onehot_g;
    assign offering  = (state_q == ST_OFFER) && cur_rdy;
    assign accept    = offering && ack;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        case (state_q)
            ST_IDLE: begin
                if (|rdy_in) begin
                    g_d     = sel(rdy_in, int'(p_q));
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (!cur_rdy) begin
                    // Withdrawal: drop the grant, leave the pointer alone and
                    // ignore any ack that arrives in this cycle.
                    state_d = ST_IDLE;
                end else if (ack) begin
                    p_d = TAG_SZ'(next_ptr);
                    if (BACK_TO_BACK && (|rest_mask)) begin
                        g_d = sel(rest_mask, next_ptr);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
        end
    end

    // rdy and tag depend only on state and rdy_in, never on ack.
    assign rdy     = offering;
    assign tag     = (state_q != ST_OFFER) ? '0 :
                     (CUSTOM_TAGS != 1'b0) ? ctag : g_q;
    assign ack_out = onehot_g & {N{accept}};

endmodule

// File: tb/tb_rr_tag_arbiter.sv
module tb_rr_tag_arbiter;

    typedef struct {
        int         id;
        logic [3:0] tag;
        logic [3:0] ao;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk;
    logic rst_n;

    // a: N=4 round-robin, b: N=4 back-to-back, c: N=4 fixed priority,
    // d: N=3 custom tags, e: N=1
    logic [1:0] tag_a, tag_b, tag_c, tag_d;
    logic [0:0] tag_e;
    logic       rdy_a, rdy_b, rdy_c, rdy_d, rdy_e;
    logic       ack_a, ack_b, ack_c, ack_d, ack_e;
    logic [3:0] rdy_in_a, rdy_in_b, rdy_in_c;
    logic [2:0] rdy_in_d;
    logic [0:0] rdy_in_e;
    logic [3:0] ack_out_a, ack_out_b, ack_out_c;
    logic [2:0] ack_out_d;
    logic [0:0] ack_out_e;
    logic [7:0] ctags_4;
    logic [5:0] ctags_d;
    logic [0:0] ctags_e;

    rr_tag_arbiter #(.N(4), .RR_MODE(1'b1), .BACK_TO_BACK(1'b0)) dut_a (
        .clk(clk), .rst(rst_n), .tag(tag_a), .rdy(rdy_a), .ack(ack_a),
        .rdy_in(rdy_in_a), .ack_out(ack_out_a), .custom_tags(ctags_4));

    rr_tag_arbiter #(.N(4), .RR_MODE(1'b1), .BACK_TO_BACK(1'b1)) dut_b (
        .clk(clk), .rst(rst_n), .tag(tag_b), .rdy(rdy_b), .ack(ack_b),
        .rdy_in(rdy_in_b), .ack_out(ack_out_b), .custom_tags(ctags_4));

    rr_tag_arbiter #(.N(4), .RR_MODE(1'b0), .BACK_TO_BACK(1'b0)) dut_c (
        .clk(clk), .rst(rst_n), .tag(tag_c), .rdy(rdy_c), .ack(ack_c),
        .rdy_in(rdy_in_c), .ack_out(ack_out_c), .custom_tags(ctags_4));

    rr_tag_arbiter #(.N(3), .CUSTOM_TAGS(1'b1)) dut_d (
        .clk(clk), .rst(rst_n), .tag(tag_d), .rdy(rdy_d), .ack(ack_d),
        .rdy_in(rdy_in_d), .ack_out(ack_out_d), .custom_tags(ctags_d));

    rr_tag_arbiter #(.N(1)) dut_e (
        .clk(clk), .rst(rst_n), .tag(tag_e), .rdy(rdy_e), .ack(ack_e),
        .rdy_in(rdy_in_e), .ack_out(ack_out_e), .custom_tags(ctags_e));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int id, input logic [3:0] t, input logic [3:0] ao);
        exp_t e;
        e.id  = id;
        e.tag = t;
        e.ao  = ao;
        exp_q.push_back(e);
    endtask

    task automatic mon_check(input int id, input logic [3:0] t, input logic [3:0] ao);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_offer: dut %0d got tag %0d ack_out %b, required no offer",
                     id, t, ao);
        end else begin
            e = exp_q.pop_front();
            if (e.id != id || e.tag != t || e.ao != ao) begin
                errors++;
                $display("FAIL offer: got dut %0d tag %0d ack_out %b, required dut %0d tag %0d ack_out %b",
                         id, t, ao, e.id, e.tag, e.ao);
            end
        end
    endtask

    // Monitor: every cycle a DUT offers a grant, it must match the next
    // expected offer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rdy_a) mon_check(0, {2'b00, tag_a}, ack_out_a);
            if (rdy_b) mon_check(1, {2'b00, tag_b}, ack_out_b);
            if (rdy_c) mon_check(2, {2'b00, tag_c}, ack_out_c);
            if (rdy_d) mon_check(3, {2'b00, tag_d}, {1'b0, ack_out_d});
            if (rdy_e) mon_check(4, {3'b000, tag_e}, {3'b000, ack_out_e});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        rdy_in_a = 4'b1111; ack_a = 1'b1;
        rdy_in_b = '0; ack_b = 1'b0;
        rdy_in_c = '0; ack_c = 1'b0;
        rdy_in_d = '0; ack_d = 1'b0;
        rdy_in_e = '0; ack_e = 1'b0;
        ctags_4  = '0;
        ctags_d  = {2'd1, 2'd3, 2'd2};
        ctags_e  = '0;

        // Reset held with all requesters ready
        repeat (3) begin
            @(negedge clk);
            chk("reset_rdy", rdy_a, 0);
            chk("reset_ack_out", ack_out_a, 0);
            chk("reset_tag", tag_a, 0);
        end

        // Round-robin with an idle bubble between offers
        push(0, 0, 4'b0001); push(0, 1, 4'b0010); push(0, 2, 4'b0100);
        push(0, 3, 4'b1000); push(0, 0, 4'b0001);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("rr_rdy_pattern", rdy_a, (i % 2 == 1));
        end

        // Move the pointer to 2, offer 2, then withdraw it with ack high
        #1;
        rdy_in_a = 4'b0010; ack_a = 1'b1; push(0, 1, 4'b0010);
        @(posedge clk); @(posedge clk); #1;
        rdy_in_a = 4'b1111; ack_a = 1'b0; push(0, 2, 4'b0000);
        @(posedge clk); @(posedge clk); #1;
        rdy_in_a = 4'b0000; ack_a = 1'b1;
        @(negedge clk);
        chk("withdraw_rdy", rdy_a, 0);
        chk("withdraw_ack_out", ack_out_a, 0);
        @(posedge clk); #1;
        rdy_in_a = 4'b1111; push(0, 2, 4'b0100);
        @(negedge clk);
        chk("idle_after_withdraw", rdy_a, 0);
        @(posedge clk); @(posedge clk); #1;
        rdy_in_a = 4'b0000; ack_a = 1'b0;
        @(posedge clk); #1;

        // Back-to-back with wrap between requesters 0 and 3
        rdy_in_b = 4'b1001; ack_b = 1'b1;
        push(1, 0, 4'b0001); push(1, 3, 4'b1000);
        push(1, 0, 4'b0001); push(1, 3, 4'b1000);
        @(negedge clk);
        chk("b2b_idle_before", rdy_b, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("b2b_rdy_continuous", rdy_b, 1);
        end
        #1;
        rdy_in_b = 4'b0000; ack_b = 1'b0;
        @(posedge clk); #1;

        // Fixed priority: requester 1 always wins
        rdy_in_c = 4'b1110; ack_c = 1'b1;
        repeat (3) push(2, 1, 4'b0010);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("fp_rdy_pattern", rdy_c, (i % 2 == 1));
        end
        #1;
        rdy_in_c = 4'b0000; ack_c = 1'b0;
        @(posedge clk); #1;

        // N=3 custom tags; pointer wraps from 2 back to 0
        rdy_in_d = 3'b111; ack_d = 1'b1;
        push(3, 2, 4'b0001); push(3, 3, 4'b0010);
        push(3, 1, 4'b0100); push(3, 2, 4'b0001);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("ct_rdy_pattern", rdy_d, (i % 2 == 1));
        end
        #1;
        rdy_in_d = 3'b000; ack_d = 1'b0;
        @(posedge clk); #1;

        // N=1
        rdy_in_e = 1'b1; ack_e = 1'b1; push(4, 0, 4'b0001);
        @(negedge clk);
        chk("n1_idle", rdy_e, 0);
        @(negedge clk);
        chk("n1_rdy", rdy_e, 1);
        #1;
        rdy_in_e = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("n1_ack_without_rdy", ack_out_e, 0);
        end
        ack_e = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
